nice_icb_mem_responder: RTL and testbench
=========================================

Name: nice_icb_mem_responder

Overview:
- ICB slave (responder) end of the NICE memory channel: accepts read/write commands from an ICB initiator such as the accelerator's memory interface and returns in-order responses.
- Backed by an internal word-addressed synchronous scratchpad with byte-lane writes.
- Used as the accelerator-local data buffer and as the memory-side model for unit-level verification of initiator blocks.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in the scratchpad (power of 2).
- BASE_ADDR, 32'h1000_0000, byte address of word 0 (DEPTH_WORDS*4 aligned).
- RSP_DEPTH, 2, maximum outstanding responses (pipeline stage + FIFO); >=2.

Ports:
- nice_clk  in  1  clock
- nice_rst_n  in  1  async active-low reset
- icb_cmd_valid  in  1  command valid
- icb_cmd_ready  out  1  command accepted when valid&ready
- icb_cmd_addr  in  32  byte address
- icb_cmd_read  in  1  1=read, 0=write
- icb_cmd_wdata  in  32  write data, lane-aligned (byte k on bits 8k+7:8k)
- icb_cmd_size  in  2  0=byte, 1=half, 2=word, 3=reserved
- icb_rsp_valid  out  1  response valid
- icb_rsp_ready  in  1  response consumed when valid&ready
- icb_rsp_rdata  out  32  read data (full aligned word)
- icb_rsp_err  out  1  response error
- idle  out  1  no response outstanding
- err_cnt  out  16  saturating count of error responses issued

Behaviour:
- Reset: reset nice_rst_n, asynchronous, active-low; clock nice_clk.
- Reset values:
  - icb_rsp_valid=0, icb_rsp_err=0, icb_rsp_rdata=0, err_cnt=0, idle=1.
  - Pipeline stage and FIFO emptied; icb_cmd_ready=1.
  - Scratchpad contents are not reset.
- Outstanding count occ = p_valid + fifo_count.
- icb_cmd_ready = (occ < RSP_DEPTH). It depends on registered state only and has no combinational path from icb_rsp_ready.
- Accept (valid&ready) at edge N:
  - Decode the command.
  - Issue the sync RAM access.
  - Load the pipeline stage: p_valid=1, p_err, p_read.
- Error decode (any one sets err):
  - addr outside [BASE_ADDR, BASE_ADDR+DEPTH_WORDS*4).
  - size==3.
  - size==1 with addr[0]!=0.
  - size==2 with addr[1:0]!=0.
- Erroneous commands perform no RAM write. Response rdata=0, err=1.
- Word index = (addr-BASE_ADDR)[log2(DEPTH_WORDS)+1:2].
- Write byte enables:
  - byte: 1<<addr[1:0]
  - half: 4'b0011<<addr[1:0]
  - word: 4'b1111
- The write commits at the accept edge. Write response: rdata=0, err per decode.
- Read returns the full aligned word, unshifted. A read accepted the cycle after a write to the same word returns the written data.
- Response output:
  - If FIFO non-empty: the head drives icb_rsp_*.
  - Else if p_valid: the stage drives icb_rsp_* (bypass).
  - Minimum latency is 1 cycle: accept at N, rsp_valid high during cycle N+1.
- Each edge, an unconsumed stage entry moves into the FIFO. A consumed bypass entry is dropped. The stage reloads on a new accept or clears.
- FIFO depth is RSP_DEPTH, circular pointers with wrap-around. Order is strictly preserved.
- Simultaneous accept + pop keeps occ unchanged. Full throughput (1 cmd/cycle) holds while icb_rsp_ready=1.
- icb_rsp_valid is held, with rsp fields stable, until icb_rsp_ready.
- err_cnt increments on each err response handshake and saturates at 16'hFFFF.
- idle = (occ==0).
- Reset mid-operation drops all outstanding responses. A write whose accept edge coincides with reset assertion is not guaranteed to complete.

Decomposition:
- Package nice_icb_pkg:
  - size encodings (ICB_SIZE_B/H/W)
  - response struct {rdata, err}
  - function size_to_be(size, addr_lo)
  - function misaligned(size, addr_lo)
- Sub-module nice_rsp_fifo: parameterised sync FIFO (push/pop/full/empty/count), reused by other NICE blocks.
- The scratchpad is inferred inline.

Test Plan:
- Word write 0x1000_0010 <= 0xDEADBEEF, then word read of the same address → write rsp err=0 at N+1, read rsp rdata=0xDEADBEEF err=0.
- Byte write 0xAA at 0x1000_0013 over word 0x11223344, then read → 0xAA223344. Half write 0x5566 at offset 2 → 0x55663344.
- Errors:
  - word read at 0x1000_0002 → err=1, rdata=0.
  - read at 0x0FFF_FFFC → err=1.
  - size=3 → err=1, no RAM change.
  - err_cnt=3 after all three.
- Backpressure with icb_rsp_ready=0, 3 reads issued back-to-back → two accepted, then icb_cmd_ready=0. Raising ready pops both in order and resumes acceptance.
- Streaming: 16 back-to-back reads with rsp_ready=1 → one rsp per cycle, latency 1, data in address order, cmd_ready never drops.
- Assert nice_rst_n low with 2 responses pending → rsp_valid=0, idle=1, cmd_ready=1 immediately. Previously written words still read back after reset.

Source files
------------

// File: rtl/nice_icb_pkg.sv
// Shared ICB definitions for the NICE memory channel: size codes, response word, lane helpers.
// Latency: none; this file holds only types and pure functions.
// Backpressure: not applicable.
package nice_icb_pkg;

    localparam logic [1:0] ICB_SIZE_B = 2'd0;
    localparam logic [1:0] ICB_SIZE_H = 2'd1;
    localparam logic [1:0] ICB_SIZE_W = 2'd2;
    localparam logic [1:0] ICB_SIZE_R = 2'd3;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } icb_rsp_t;

    // Byte enables for a lane-aligned access; reserved size enables nothing.
    function automatic logic [3:0] size_to_be(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            ICB_SIZE_B: return 4'b0001 << addr_lo;
            ICB_SIZE_H: return 4'b0011 << addr_lo;
            ICB_SIZE_W: return 4'b1111;
            default:    return 4'b0000;
        endcase
    endfunction

    // Natural-alignment violation for half and word accesses.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            ICB_SIZE_H: return addr_lo[0];
            ICB_SIZE_W: return (addr_lo != 2'b00);
            default:    return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/nice_rsp_fifo.sv
// Generic synchronous FIFO with circular pointers, used for response queuing across NICE blocks.
// Latency: a pushed entry is visible at the head the cycle after the push edge.
// Backpressure: push is ignored when full and pop when empty; callers gate on full/empty.
module nice_rsp_fifo #(
    parameter int W     = 33,
    parameter int DEPTH = 2
) (
    input  logic                         nice_clk,
    input  logic                         nice_rst_n,
    input  logic                         push,
    input  logic [W-1:0]                 push_dat,
    input  logic                         pop,
    output logic [W-1:0]                 pop_dat,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  store [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign pop_dat = store[rd_ptr];

    // Storage array carries no reset; only the pointers define validity.
    always_ff @(posedge nice_clk) begin
        if (push_ok) store[wr_ptr] <= push_dat;
    end

    // Pointer and occupancy update; pointers wrap at DEPTH-1 so any depth works.
    always_ff @(posedge nice_clk or negedge nice_rst_n) begin
        if (!nice_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/nice_icb_mem_responder.sv
// ICB responder backed by a word-addressed scratchpad with byte-lane writes; responses in order.
// Latency: 1 cycle from accept to icb_rsp_valid via the bypass stage; more when the FIFO holds entries.
// Backpressure: icb_cmd_ready drops once RSP_DEPTH responses are outstanding; icb_rsp_* held until icb_rsp_ready.
module nice_icb_mem_responder
    import nice_icb_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
    parameter int          RSP_DEPTH   = 2
) (
    input  logic        nice_clk,
    input  logic        nice_rst_n,
    input  logic        icb_cmd_valid,
    output logic        icb_cmd_ready,
    input  logic [31:0] icb_cmd_addr,
    input  logic        icb_cmd_read,
    input  logic [31:0] icb_cmd_wdata,
    input  logic [1:0]  icb_cmd_size,
    output logic        icb_rsp_valid,
    input  logic        icb_rsp_ready,
    output logic [31:0] icb_rsp_rdata,
    output logic        icb_rsp_err,
    output logic        idle,
    output logic [15:0] err_cnt
);
    localparam int          AW   = $clog2(DEPTH_WORDS);
    localparam int          CW   = $clog2(RSP_DEPTH + 1);
    localparam int          RW   = $bits(icb_rsp_t);
    localparam logic [31:0] SPAN = 32'(DEPTH_WORDS * 4);

    logic [31:0]   mem [DEPTH_WORDS];
    logic [31:0]   ram_q;

    logic          cmd_hsk;
    logic [31:0]   offset;
    logic [AW-1:0] widx;
    logic          dec_err;
    logic [3:0]    be;

    logic          p_valid;
    logic          p_err;
    logic          p_read;
    icb_rsp_t      stage_rsp;
    icb_rsp_t      head_rsp;
    icb_rsp_t      out_rsp;

    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [RW-1:0] fifo_head;
    logic [CW:0]   occ;
    logic          rsp_hsk;

    // Command decode: offset wraps below BASE_ADDR, so a single compare covers both range ends.
    assign cmd_hsk = icb_cmd_valid && icb_cmd_ready;
    assign offset  = icb_cmd_addr - BASE_ADDR;
    assign widx    = offset[AW+1:2];
    assign dec_err = (offset >= SPAN) || (icb_cmd_size == ICB_SIZE_R)
                     || misaligned(icb_cmd_size, icb_cmd_addr[1:0]);
    assign be      = size_to_be(icb_cmd_size, icb_cmd_addr[1:0]);

    // Scratchpad: writes commit and reads launch at the accept edge; errored commands touch nothing.
    always_ff @(posedge nice_clk) begin
        if (cmd_hsk && !dec_err) begin
            if (icb_cmd_read) begin
                ram_q <= mem[widx];
            end else begin
                for (int k = 0; k < 4; k++) begin
                    if (be[k]) mem[widx][8*k +: 8] <= icb_cmd_wdata[8*k +: 8];
                end
            end
        end
    end

    // Pipeline stage: tracks the response whose RAM read is in flight this cycle.
    always_ff @(posedge nice_clk or negedge nice_rst_n) begin
        if (!nice_rst_n) begin
            p_valid <= 1'b0;
            p_err   <= 1'b0;
            p_read  <= 1'b0;
        end else begin
            p_valid <= cmd_hsk;
            p_err   <= cmd_hsk && dec_err;
            p_read  <= cmd_hsk && icb_cmd_read;
        end
    end

    // Stage response: ram_q is only meaningful for a good read, so everything else reports zero.
    always_comb begin
        stage_rsp       = '0;
        stage_rsp.err   = p_err;
        stage_rsp.rdata = (p_read && !p_err) ? ram_q : 32'h0;
    end

    // An unconsumed stage entry drains into the FIFO; a stage entry taken through the bypass is dropped.
    assign fifo_pop  = !fifo_empty && icb_rsp_ready;
    assign fifo_push = p_valid && !fifo_full && !(fifo_empty && icb_rsp_ready);
    assign head_rsp  = icb_rsp_t'(fifo_head);

    nice_rsp_fifo #(
        .W     (RW),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .nice_clk   (nice_clk),
        .nice_rst_n (nice_rst_n),
        .push       (fifo_push),
        .push_dat   (stage_rsp),
        .pop        (fifo_pop),
        .pop_dat    (fifo_head),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (fifo_count)
    );

    // Response mux: the FIFO head is older than the stage, so it always goes first.
    always_comb begin
        out_rsp       = '0;
        icb_rsp_valid = 1'b0;
        if (!fifo_empty) begin
            out_rsp       = head_rsp;
            icb_rsp_valid = 1'b1;
        end else if (p_valid) begin
            out_rsp       = stage_rsp;
            icb_rsp_valid = 1'b1;
        end
    end

    assign icb_rsp_rdata = out_rsp.rdata;
    assign icb_rsp_err   = out_rsp.err;
    assign rsp_hsk       = icb_rsp_valid && icb_rsp_ready;

    // Ready is a function of registered occupancy only, never of icb_rsp_ready.
    assign occ           = {{CW{1'b0}}, p_valid} + {1'b0, fifo_count};
    assign icb_cmd_ready = (occ < (CW+1)'(RSP_DEPTH));
    assign idle          = (occ == '0);

    // Saturating count of error responses actually delivered.
    always_ff @(posedge nice_clk or negedge nice_rst_n) begin
        if (!nice_rst_n) begin
            err_cnt <= 16'h0;
        end else if (rsp_hsk && icb_rsp_err && (err_cnt != 16'hFFFF)) begin
            err_cnt <= err_cnt + 16'h1;
        end
    end

endmodule

// File: tb/tb_nice_icb_mem_responder.sv
// Bench for the ICB scratchpad responder: directed scenarios plus randomized traffic.
// Latency: expected responses come from an in-order queue filled at accept time.
// Backpressure: icb_rsp_ready is driven both as fixed levels and randomly.
module tb_nice_icb_mem_responder;
    localparam int          DEPTH_WORDS = 1024;
    localparam logic [31:0] BASE        = 32'h1000_0000;
    localparam int          RSP_DEPTH   = 2;

    logic        nice_clk = 1'b0;
    logic        nice_rst_n;
    logic        icb_cmd_valid;
    logic        icb_cmd_ready;
    logic [31:0] icb_cmd_addr;
    logic        icb_cmd_read;
    logic [31:0] icb_cmd_wdata;
    logic [1:0]  icb_cmd_size;
    logic        icb_rsp_valid;
    logic        icb_rsp_ready;
    logic [31:0] icb_rsp_rdata;
    logic        icb_rsp_err;
    logic        idle;
    logic [15:0] err_cnt;

    nice_icb_mem_responder #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .BASE_ADDR   (BASE),
        .RSP_DEPTH   (RSP_DEPTH)
    ) dut (
        .nice_clk      (nice_clk),
        .nice_rst_n    (nice_rst_n),
        .icb_cmd_valid (icb_cmd_valid),
        .icb_cmd_ready (icb_cmd_ready),
        .icb_cmd_addr  (icb_cmd_addr),
        .icb_cmd_read  (icb_cmd_read),
        .icb_cmd_wdata (icb_cmd_wdata),
        .icb_cmd_size  (icb_cmd_size),
        .icb_rsp_valid (icb_rsp_valid),
        .icb_rsp_ready (icb_rsp_ready),
        .icb_rsp_rdata (icb_rsp_rdata),
        .icb_rsp_err   (icb_rsp_err),
        .idle          (idle),
        .err_cnt       (err_cnt)
    );

    always #5 nice_clk = ~nice_clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    int          n_chk = 0;
    int          n_err = 0;
    int          n_acc = 0;
    exp_t        exp_q[$];
    logic [31:0] mdl_mem [DEPTH_WORDS];
    logic [15:0] mdl_errcnt = 16'h0;
    bit          rand_rdy = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference decode: legal iff inside the window, a defined size, and naturally aligned.
    function automatic logic mdl_bad(input logic [31:0] addr, input logic [1:0] size);
        if (addr < BASE || addr >= BASE + DEPTH_WORDS * 4) return 1'b1;
        if (size == 2'd3) return 1'b1;
        if ((addr % (32'd1 << size)) != 0) return 1'b1;
        return 1'b0;
    endfunction

    // Reference bookkeeping at the negedge: outstanding set, response order, writes, error count.
    always @(negedge nice_clk) begin
        exp_t e;
        int   idx;
        int   lo;
        if (!nice_rst_n) begin
            exp_q.delete();
            mdl_errcnt = 16'h0;
        end else begin
            chk("rsp_valid", icb_rsp_valid, exp_q.size() != 0);
            chk("cmd_ready", icb_cmd_ready, exp_q.size() < RSP_DEPTH);
            chk("idle", idle, exp_q.size() == 0);
            chk("err_cnt", err_cnt, mdl_errcnt);
            if (icb_rsp_valid && icb_rsp_ready && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("rsp_rdata", icb_rsp_rdata, e.rdata);
                chk("rsp_err", icb_rsp_err, e.err);
                if (e.err && mdl_errcnt != 16'hFFFF) mdl_errcnt = mdl_errcnt + 16'h1;
            end
            if (icb_cmd_valid && icb_cmd_ready) begin
                n_acc++;
                e.err   = mdl_bad(icb_cmd_addr, icb_cmd_size);
                e.rdata = 32'h0;
                if (!e.err) begin
                    idx = int'((icb_cmd_addr - BASE) / 4);
                    lo  = int'(icb_cmd_addr % 4);
                    if (icb_cmd_read) begin
                        e.rdata = mdl_mem[idx];
                    end else begin
                        for (int k = lo; k < lo + (1 << icb_cmd_size); k++)
                            mdl_mem[idx][8*k +: 8] = icb_cmd_wdata[8*k +: 8];
                    end
                end
                exp_q.push_back(e);
            end
        end
    end

    // Present one command and hold it until accepted; returns just after the accept edge.
    task automatic send(input logic rd, input logic [31:0] addr, input logic [31:0] wd, input logic [1:0] sz);
        logic ok = 1'b0;
        icb_cmd_valid = 1'b1;
        icb_cmd_read  = rd;
        icb_cmd_addr  = addr;
        icb_cmd_wdata = wd;
        icb_cmd_size  = sz;
        for (int t = 0; t < 200; t++) begin
            @(negedge nice_clk);
            if (icb_cmd_ready) begin
                ok = 1'b1;
                break;
            end
        end
        chk("send_accepted", ok, 1'b1);
        @(posedge nice_clk);
        #1;
        icb_cmd_valid = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 200; t++) begin
            @(negedge nice_clk);
            if (idle) break;
        end
        chk("drain_idle", idle, 1'b1);
        @(posedge nice_clk);
        #1;
    endtask

    initial begin
        int          t0;
        int          acc0;
        logic [31:0] a;
        logic [1:0]  sz;
        int          r;

        nice_rst_n    = 1'b0;
        icb_cmd_valid = 1'b0;
        icb_cmd_read  = 1'b0;
        icb_cmd_addr  = 32'h0;
        icb_cmd_wdata = 32'h0;
        icb_cmd_size  = 2'd0;
        icb_rsp_ready = 1'b1;

        repeat (2) @(posedge nice_clk);
        #1;
        chk("rst_rsp_valid", icb_rsp_valid, 1'b0);
        chk("rst_rsp_err", icb_rsp_err, 1'b0);
        chk("rst_rsp_rdata", icb_rsp_rdata, 32'h0);
        chk("rst_err_cnt", err_cnt, 16'h0);
        chk("rst_idle", idle, 1'b1);
        chk("rst_cmd_ready", icb_cmd_ready, 1'b1);
        nice_rst_n = 1'b1;
        @(posedge nice_clk);
        #1;

        // Word write then read back; monitor checks latency-1 and data.
        send(1'b0, 32'h1000_0010, 32'hDEADBEEF, 2'd2);
        send(1'b1, 32'h1000_0010, 32'h0, 2'd2);
        drain();

        // Sub-word merges over a known word.
        send(1'b0, 32'h1000_0010, 32'h11223344, 2'd2);
        send(1'b0, 32'h1000_0013, 32'hAA000000, 2'd0);
        send(1'b1, 32'h1000_0010, 32'h0, 2'd2);
        send(1'b0, 32'h1000_0012, 32'h55660000, 2'd1);
        send(1'b1, 32'h1000_0010, 32'h0, 2'd2);
        drain();
        chk("merged_word", mdl_mem[4], 32'h55663344);

        // Error cases; reserved-size write must leave the word alone.
        send(1'b1, 32'h1000_0002, 32'h0, 2'd2);
        send(1'b1, 32'h0FFF_FFFC, 32'h0, 2'd2);
        send(1'b0, 32'h1000_0010, 32'hFFFFFFFF, 2'd3);
        send(1'b1, 32'h1000_0010, 32'h0, 2'd2);
        drain();
        chk("err_cnt_three", err_cnt, 16'd3);

        // Fill a 32-word window with known data.
        for (int i = 0; i < 32; i++) send(1'b0, BASE + 32'(i * 4), $urandom, 2'd2);
        drain();

        // Streaming: 16 back-to-back reads must take exactly 16 cycles.
        t0 = int'($time / 10);
        for (int i = 0; i < 16; i++) send(1'b1, BASE + 32'(i * 4), 32'h0, 2'd2);
        chk("stream_cycles", 32'(int'($time / 10) - t0), 32'd16);
        drain();

        // Backpressure: two accepted, third held off until the consumer drains.
        icb_rsp_ready = 1'b0;
        acc0 = n_acc;
        send(1'b1, BASE + 32'h0, 32'h0, 2'd2);
        send(1'b1, BASE + 32'h4, 32'h0, 2'd2);
        icb_cmd_valid = 1'b1;
        icb_cmd_read  = 1'b1;
        icb_cmd_addr  = BASE + 32'h8;
        icb_cmd_size  = 2'd2;
        repeat (3) begin
            @(negedge nice_clk);
            chk("bp_ready_low", icb_cmd_ready, 1'b0);
            chk("bp_rsp_held", icb_rsp_valid, 1'b1);
        end
        chk("bp_accepts", 32'(n_acc - acc0), 32'd2);
        @(posedge nice_clk);
        #1;
        icb_rsp_ready = 1'b1;
        send(1'b1, BASE + 32'h8, 32'h0, 2'd2);
        drain();

        // Randomized traffic with random consumer stalls.
        rand_rdy = 1'b1;
        for (int n = 0; n < 400; n++) begin
            r  = int'($urandom_range(0, 19));
            sz = 2'($urandom_range(0, 2));
            a  = BASE + 32'($urandom_range(0, 31) * 4) + 32'($urandom_range(0, 3));
            if (r == 0) sz = 2'd3;
            if (r == 1) a = BASE + 32'(DEPTH_WORDS * 4) + 32'($urandom_range(0, 31) * 4);
            if (r == 2) a = BASE - 32'd4 - 32'($urandom_range(0, 31) * 4);
            send(1'($urandom_range(0, 1)), a, $urandom, sz);
        end
        rand_rdy = 1'b0;
        @(posedge nice_clk);
        #1;
        icb_rsp_ready = 1'b1;
        drain();

        // Reset with two responses pending.
        icb_rsp_ready = 1'b0;
        send(1'b1, BASE + 32'h10, 32'h0, 2'd2);
        send(1'b1, BASE + 32'h14, 32'h0, 2'd2);
        nice_rst_n = 1'b0;
        #1;
        chk("midrst_rsp_valid", icb_rsp_valid, 1'b0);
        chk("midrst_idle", idle, 1'b1);
        chk("midrst_cmd_ready", icb_cmd_ready, 1'b1);
        chk("midrst_err_cnt", err_cnt, 16'h0);
        repeat (2) @(posedge nice_clk);
        #1;
        nice_rst_n    = 1'b1;
        icb_rsp_ready = 1'b1;
        @(posedge nice_clk);
        #1;
        send(1'b1, BASE + 32'h10, 32'h0, 2'd2);
        send(1'b1, BASE + 32'h0, 32'h0, 2'd2);
        drain();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    // Random consumer stalls while enabled.
    initial begin
        forever begin
            @(posedge nice_clk);
            #1;
            if (rand_rdy) icb_rsp_ready = ($urandom_range(0, 3) != 0);
        end
    end

endmodule
